// File: rtl/forward_merge_arbiter_pkg.sv
// rtl/forward_merge_arbiter_pkg.sv - shared router constants for the forward merge arbiter
package forward_merge_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 23;

    // dy field position inside a packet; carried through untouched
    localparam int DY_MSB = 20;
    localparam int DY_LSB = 12;

    localparam int GRANT_IDX_W = 3;

    localparam logic [GRANT_IDX_W-1:0] REQ_EAST  = 3'd0;
    localparam logic [GRANT_IDX_W-1:0] REQ_WEST  = 3'd1;
    localparam logic [GRANT_IDX_W-1:0] REQ_LOCAL = 3'd2;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin winner selection
module rr_priority_select
    import forward_merge_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [GRANT_IDX_W-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [GRANT_IDX_W-1:0] grant_idx_o,
    output logic                   any_o
);

    always_comb begin : search
        int cand;
        cand        = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        // Search starts just past the previous winner and wraps; last_grant_i < NUM_REQ.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = GRANT_IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/forward_merge_arbiter.sv
// rtl/forward_merge_arbiter.sv - registered round-robin merge of NUM_REQ streams; optional FWD_ARB_PERF_CNT_EN grant counters
module forward_merge_arbiter
    import forward_merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [GRANT_IDX_W-1:0]        grant_idx
`ifdef FWD_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic [GRANT_IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [GRANT_IDX_W-1:0] last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]     sel_grant;
    logic [GRANT_IDX_W-1:0] sel_idx;
    logic                   sel_any;
    logic                   load;
    logic                   accept;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (sel_grant),
        .grant_idx_o  (sel_idx),
        .any_o        (sel_any)
    );

    always_comb begin
        load   = !dout_valid_q || dout_ready;
        // rst_n gating keeps req_ready low for the whole reset window
        accept = load && sel_any && rst_n;
        req_ready = accept ? sel_grant : '0;

        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;

        if (load) begin
            dout_valid_d = sel_any;
            dout_d       = '0;
            grant_idx_d  = '0;
            if (sel_any) begin
                dout_d       = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                grant_idx_d  = sel_idx;
                last_grant_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            grant_idx_q  <= '0;
            last_grant_q <= GRANT_IDX_W'(NUM_REQ - 1);
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign grant_idx  = grant_idx_q;

`ifdef FWD_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_forward_merge_arbiter.sv
// tb/tb_forward_merge_arbiter.sv - scoreboard bench for forward_merge_arbiter
module tb_forward_merge_arbiter;

    localparam int DW = 23;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic [2:0]        grant_idx;
`ifdef FWD_ARB_PERF_CNT_EN
    logic [NR*16-1:0]  grant_cnt;
`endif

    forward_merge_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .grant_idx  (grant_idx)
`ifdef FWD_ARB_PERF_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    idx;
        logic [DW-1:0] data;
    } pkt_t;

    int   checks   = 0;
    int   failures = 0;
    pkt_t exp_q[$];
    int   m_last;
    logic m_dv;
    int   m_cnt [NR];
    int   hs_since2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_dv   = 1'b0;
        m_last = NR - 1;
        exp_q.delete();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    // One cycle: drive at negedge+1, compare against the model at negedge+2, advance the model.
    task automatic drive(input logic [NR-1:0] v, input logic rdy, input logic [DW-1:0] base);
        logic          load_m;
        logic          any_m;
        int            w;
        logic [NR-1:0] exp_ready;
        @(negedge clk);
        #1;
        req_valid  = v;
        dout_ready = rdy;
        for (int i = 0; i < NR; i++)
            req_data[i*DW +: DW] = v[i] ? base + DW'(i) : {DW{1'bx}};
        #1;
        load_m = !m_dv || rdy;
        any_m  = 1'b0;
        w      = 0;
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_last + k) % NR;
            if (!any_m && v[c]) begin
                any_m = 1'b1;
                w     = c;
            end
        end
        exp_ready = (load_m && any_m) ? NR'(1 << w) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("dout_valid", 64'(dout_valid), 64'(m_dv));
        if (!m_dv) check("grant_idx_idle", 64'(grant_idx), 64'd0);
        if (load_m) begin
            if (any_m) begin
                exp_q.push_back({3'(w), base + DW'(w)});
                m_last = w;
                m_cnt[w]++;
            end
            m_dv = any_m;
        end
    endtask

    initial begin : monitor
        pkt_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 64'(dout), 64'(e.data));
                    check("grant_idx", 64'(grant_idx), 64'(e.idx));
                end
            end
        end
    end

    logic [NR-1:0] rr_tab [6];

    initial begin
        rr_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        model_reset();
        req_valid = '1;
        #2;
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // all valid, ready high: strict rotation 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 1'b1, DW'(23'h100 + 16 * k));
            check("rr_order", 64'(req_ready), 64'(rr_tab[k]));
        end

        // single requester streams one packet per cycle
        for (int k = 0; k < 4; k++) begin
            drive(3'b010, 1'b1, 23'h012344);
            check("solo_ready", 64'(req_ready), 64'(3'b010));
            if (k > 0) check("solo_dout", 64'(dout), 64'(23'h012345));
        end
        drive(3'b000, 1'b1, '0);
        drive(3'b000, 1'b1, '0);

        // stall for 5 cycles with everyone requesting, then release
        drive(3'b111, 1'b1, 23'h200);
        for (int k = 0; k < 5; k++) begin
            drive(3'b111, 1'b0, DW'(23'h300 + 16 * k));
            check("stall_dout", 64'(dout), 64'(exp_q[0].data));
            check("stall_grant_idx", 64'(grant_idx), 64'(exp_q[0].idx));
        end
        drive(3'b111, 1'b1, 23'h400);
        drive(3'b111, 1'b1, 23'h410);

        // asynchronous reset while a packet is held
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("async_rst_dout_valid", 64'(dout_valid), 64'd0);
        check("async_rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b111, 1'b1, 23'h500);
        check("first_after_rst", 64'(req_ready), 64'(3'b001));

        // local requester always valid, others and downstream pseudo-random
        hs_since2 = 0;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] r;
            r = $urandom;
            drive({1'b1, r[1:0]}, r[2] | r[3], DW'(23'h1000 + 4 * k));
            if (|req_ready) begin
                if (req_ready[2]) hs_since2 = 0;
                else hs_since2++;
                check("local_starved", 64'(hs_since2 >= NR), 64'd0);
            end
        end
        drive(3'b000, 1'b1, '0);
        drive(3'b000, 1'b1, '0);
        drive(3'b000, 1'b1, '0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

`ifdef FWD_ARB_PERF_CNT_EN
        for (int k = 0; k < 70000; k++) drive(3'b001, 1'b1, DW'(k));
        drive(3'b000, 1'b1, '0);
        drive(3'b000, 1'b1, '0);
        for (int i = 0; i < NR; i++)
            check("grant_cnt", 64'(grant_cnt[i*16 +: 16]),
                  64'((m_cnt[i] > 65535) ? 65535 : m_cnt[i]));
        check("grant_cnt0_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
